// File: rtl/pwm_pkg.sv
// ============================================================================
// pwm_pkg
// Shared constants, channel-mode encoding and per-channel output helpers
// for the 16-channel PWM peripheral.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int         PRESCALE_DEFAULT = 13;
  localparam int         CNT_W_DEFAULT    = 8;
  localparam logic [7:0] DUTY_FULL        = 8'hFF;
  localparam int         NUM_CH           = 16;

  typedef enum logic [1:0] {
    CH_OFF = 2'd0,
    CH_ON  = 2'd1,
    CH_PWM = 2'd2
  } ch_mode_e;

  function automatic ch_mode_e ch_mode(input logic en_out, input logic en_pwm);
    ch_mode_e m;
    if (!en_out) begin
      m = CH_OFF;
    end else if (!en_pwm) begin
      m = CH_ON;
    end else begin
      m = CH_PWM;
    end
    return m;
  endfunction

  function automatic logic ch_level(input ch_mode_e mode, input logic pwm_level);
    logic v;
    case (mode)
      CH_ON:   v = 1'b1;
      CH_PWM:  v = pwm_level;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_prescaler.sv
// ============================================================================
// pwm_prescaler
// Free-running divider: counts 0..PRESCALE-1 and raises tick on the last count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int               c_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_W-1:0]   c_LAST = c_W'(PRESCALE - 1);

  logic [c_W-1:0] r_cnt;
  logic           w_last;

  assign w_last = (r_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_W'(1);
    end
  end

  assign tick = w_last;

endmodule

`default_nettype wire

// File: rtl/pwm_peripheral.sv
// ============================================================================
// pwm_peripheral
// 16-channel PWM output stage sharing one period counter and one duty code.
// Optional macro PWM_DUTY_SHADOW_EN latches the duty at each period wrap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en_reg_out,
  input  logic [NUM_CH-1:0] en_reg_pwm,
  input  logic [CNT_W-1:0]  pwm_duty,
  output logic [NUM_CH-1:0] out,
  output logic              pwm_sync
);

  localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_DUTY_FULL = {CNT_W{1'b1}};

  logic              w_tick;
  logic              w_wrap;
  logic [CNT_W-1:0]  r_period;
  logic              r_sync;
  logic [CNT_W-1:0]  w_duty;
  logic              w_level;
  logic [NUM_CH-1:0] w_next;
  logic [NUM_CH-1:0] r_out;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_wrap = w_tick && (r_period == c_CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period <= '0;
      r_sync   <= 1'b0;
    end else begin
      if (w_tick) begin
        r_period <= r_period + CNT_W'(1);
      end
      r_sync <= w_wrap;
    end
  end

`ifdef PWM_DUTY_SHADOW_EN
  logic [CNT_W-1:0] r_duty_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty_sh <= '0;
    end else if (w_wrap) begin
      r_duty_sh <= pwm_duty;
    end
  end

  assign w_duty = r_duty_sh;
`else
  assign w_duty = pwm_duty;
`endif

  // Full-scale duty must also cover the last count, which counter < duty misses.
  assign w_level = (w_duty == c_DUTY_FULL) ? 1'b1 : (r_period < w_duty);

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_next[i] = ch_level(ch_mode(en_reg_out[i], en_reg_pwm[i]), w_level);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_next;
    end
  end

  assign out      = r_out;
  assign pwm_sync = r_sync;

endmodule

`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
// ============================================================================
// tb_pwm_peripheral
// Directed bench for pwm_peripheral: static vector table plus timed sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_peripheral;
  import pwm_pkg::*;

`ifdef PWM_DUTY_SHADOW_EN
  localparam bit c_SHADOW = 1'b1;
`else
  localparam bit c_SHADOW = 1'b0;
`endif
  localparam int c_PERIOD = 3328;
  localparam int c_LIMIT  = 4000;

  typedef struct {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] exp_out;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] en_reg_out;
  logic [15:0] en_reg_pwm;
  logic [7:0]  pwm_duty;
  logic [15:0] out;
  logic        pwm_sync;

  int errors = 0;
  int checks = 0;

  always #50 clk = ~clk;

  pwm_peripheral dut (
    .clk        (clk),
    .rst        (rst),
    .en_reg_out (en_reg_out),
    .en_reg_pwm (en_reg_pwm),
    .pwm_duty   (pwm_duty),
    .out        (out),
    .pwm_sync   (pwm_sync)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sync(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!pwm_sync && n < c_LIMIT);
    check("sync_seen", 32'(pwm_sync), 32'd1);
  endtask

  task automatic count_high(input int ncyc, output int h);
    h = 0;
    for (int i = 0; i < ncyc; i++) begin
      h += int'(out[0]);
      step();
    end
  endtask

  task automatic measure_runs(output int hi, output int lo);
    int g;
    g = 0;
    while (!out[0] && g < c_LIMIT) begin
      step();
      g++;
    end
    hi = 0;
    while (out[0] && hi < 2 * c_LIMIT) begin
      hi++;
      step();
    end
    lo = 0;
    while (!out[0] && lo < 2 * c_LIMIT) begin
      lo++;
      step();
    end
  endtask

  vec_t vecs[10];

  initial begin
    int n, h, hi, lo;
    logic [7:0] prev_duty;

    vecs[0] = '{16'hFFFF, 16'h0000, 8'h00, 16'hFFFF};
    vecs[1] = '{16'h0000, 16'h0000, 8'h00, 16'h0000};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 8'h00, 16'h0000};
    vecs[3] = '{16'hA5A5, 16'h0F0F, 8'h00, 16'hA0A0};
    vecs[4] = '{16'h1234, 16'h1200, 8'h00, 16'h0034};
    vecs[5] = '{16'h0000, 16'hFFFF, 8'hFF, 16'h0000};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 8'hFF, 16'hFFFF};
    vecs[7] = '{16'h0000, 16'h0000, 8'hFF, 16'h0000};
    vecs[8] = '{16'hA5A5, 16'h0F0F, 8'hFF, 16'hA5A5};
    vecs[9] = '{16'h8001, 16'hFFFE, 8'hFF, 16'h8001};

    rst        = 1'b1;
    en_reg_out = 16'h0000;
    en_reg_pwm = 16'h0000;
    pwm_duty   = 8'h00;
    step(3);
    check("reset_out", 32'(out), 32'h0);
    check("reset_sync", 32'(pwm_sync), 32'h0);
    rst = 1'b0;

    // Static vectors: duty is settled across a wrap first so both duty paths agree.
    prev_duty = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].duty != prev_duty) begin
        pwm_duty = vecs[i].duty;
        wait_sync(n);
        step();
        prev_duty = vecs[i].duty;
      end
      en_reg_out = vecs[i].en_out;
      en_reg_pwm = vecs[i].en_pwm;
      step();
      check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
    end

    // Half duty on channel 0: high/low runs and sync period.
    en_reg_out = 16'h0001;
    en_reg_pwm = 16'h0001;
    pwm_duty   = 8'h80;
    wait_sync(n);
    wait_sync(n);
    check("sync_period", 32'(n), 32'(c_PERIOD));
    measure_runs(hi, lo);
    check("duty80_high", 32'(hi), 32'd1664);
    check("duty80_low", 32'(lo), 32'd1664);
    check("duty80_other_ch", 32'(out & 16'hFFFE), 32'h0);

    // Mid-period enable toggle and duty change, then verify the period is undisturbed.
    wait_sync(n);
    step(500);
    check("toggle_pre", 32'(out[0]), 32'd1);
    en_reg_out = 16'h0000;
    step();
    check("toggle_off", 32'(out[0]), 32'd0);
    en_reg_out = 16'h0001;
    step();
    check("toggle_on", 32'(out[0]), 32'd1);
    step(1498);
    check("duty_chg_pre", 32'(out[0]), 32'd0);
    pwm_duty = 8'hFF;
    step();
    check("duty_chg_next", 32'(out[0]), c_SHADOW ? 32'd0 : 32'd1);
    pwm_duty = 8'h80;
    wait_sync(n);
    check("toggle_period", 32'(2001 + n), 32'(c_PERIOD));

    // Duty 0 and full scale across two periods.
    pwm_duty = 8'h00;
    wait_sync(n);
    step();
    count_high(2 * c_PERIOD, h);
    check("duty00_high", 32'(h), 32'd0);
    pwm_duty = 8'hFF;
    wait_sync(n);
    step();
    count_high(2 * c_PERIOD, h);
    check("dutyFF_high", 32'(h), 32'(2 * c_PERIOD));

    // Minimum non-zero duty.
    pwm_duty = 8'h01;
    wait_sync(n);
    count_high(c_PERIOD, h);
    check("duty01_high", 32'(h), 32'd13);

    // Duty 0x40 -> 0xC0 change 100 clk into a period.
    pwm_duty = 8'h40;
    wait_sync(n);
    h = 0;
    for (int i = 0; i < c_PERIOD; i++) begin
      h += int'(out[0]);
      if (i == 100) pwm_duty = 8'hC0;
      step();
    end
    check("shadow_cur_high", 32'(h), c_SHADOW ? 32'd832 : 32'd2496);
    check("shadow_wrap_sync", 32'(pwm_sync), 32'd1);
    count_high(c_PERIOD, h);
    check("shadow_next_high", 32'(h), 32'd2496);

    // Reset pulse at counter 100.
    pwm_duty = 8'h80;
    wait_sync(n);
    step(1305);
    check("rst_pre_out", 32'(out[0]), 32'd1);
    rst = 1'b1;
    step();
    check("rst_out", 32'(out), 32'h0);
    check("rst_sync", 32'(pwm_sync), 32'h0);
    rst = 1'b0;
    n = 0;
    h = 0;
    do begin
      step();
      n++;
      h += int'(out[0]);
    end while (!pwm_sync && n < c_LIMIT);
    check("rst_first_sync", 32'(n), 32'(c_PERIOD));
    check("rst_first_high", 32'(h), c_SHADOW ? 32'd0 : 32'd1664);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
